// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot / thermometer / scan decoder with valid/ready on both sides.
// A scan request emits one one-hot beat per index from sel up to OUT_W-1.
module onehot_decoder_pipe #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y,
    output logic [SEL_W-1:0] y_idx,
    output logic             out_last,
    output logic             err
);

    generate
        if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
            $error("onehot_decoder_pipe: SEL_W must be in 1..6");
        end
        if (OUT_W != 2 ** SEL_W) begin : g_bad_out_w
            $error("onehot_decoder_pipe: OUT_W must equal 2**SEL_W");
        end
    endgenerate

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(OUT_W - 1);

    // Handshake: a request transfers on a rising edge with in_valid && in_ready;
    // a beat transfers on a rising edge with out_valid && out_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t           state;
    logic             accept;
    logic             consume;
    logic [OUT_W-1:0] sel_onehot;
    logic [OUT_W-1:0] sel_therm;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            SCAN:    in_ready = out_ready & out_last;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // Thermometer is one-hot shifted up by one minus one; the top bit wraps to all-ones.
    assign sel_onehot = OUT_W'(1) << sel;
    assign sel_therm  = (sel_onehot << 1) - OUT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            y         <= '0;
            y_idx     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y_idx     <= sel;
            out_last  <= 1'b1;
            err       <= 1'b0;
            state     <= HOLD;
            case (mode)
                MODE_ONEHOT: y <= sel_onehot;
                MODE_THERM:  y <= sel_therm;
                MODE_SCAN: begin
                    y <= sel_onehot;
                    if (sel != TOP_IDX) begin
                        out_last <= 1'b0;
                        state    <= SCAN;
                    end
                end
                default: begin
                    y   <= '0;
                    err <= 1'b1;
                end
            endcase
        end else if (consume) begin
            if (state == SCAN && !out_last) begin
                y        <= y << 1;
                y_idx    <= y_idx + SEL_W'(1);
                out_last <= ((y_idx + SEL_W'(1)) == TOP_IDX);
            end else begin
                // Clearing the beat fields keeps y all-zero whenever out_valid is low.
                state     <= IDLE;
                out_valid <= 1'b0;
                y         <= '0;
                y_idx     <= '0;
                out_last  <= 1'b0;
                err       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: directed table and corner sequences at SEL_W=3,
// then per-width sweeps and randomized traffic against a beat-queue reference model.
module tb_onehot_decoder_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int go_sel   = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- main SEL_W=3 instance ----------------
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [2:0] y_idx;
    logic       out_last;
    logic       err;

    onehot_decoder_pipe #(.SEL_W(3), .OUT_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_idx     (y_idx),
        .out_last  (out_last),
        .err       (err)
    );

    typedef struct {
        logic [2:0] sel;
        logic [1:0] mode;
        logic [7:0] y;
        logic [2:0] idx;
        logic       last;
        logic       err;
    } vec_t;

    typedef struct packed {
        logic [63:0] y;
        logic [7:0]  idx;
        logic        last;
        logic        err;
    } beat_t;

    task automatic check_beat(input string tag, input logic [7:0] ey, input logic [2:0] ei,
                              input logic el, input logic ee);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_y"}, y, ey);
        check({tag, "_idx"}, y_idx, ei);
        check({tag, "_last"}, out_last, el);
        check({tag, "_err"}, err, ee);
    endtask

    task automatic drive_req(input logic [2:0] s, input logic [1:0] m, input logic ordy);
        @(negedge clk);
        in_valid  = 1'b1;
        sel       = s;
        mode      = m;
        out_ready = ordy;
        #1;
        check("req_in_ready", in_ready, 1'b1);
    endtask

    // ---------------- per-width sweep + randomized scoreboard ----------------
    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int SW = (g == 0) ? 1 : (g == 1) ? 3 : 5;
        localparam int OW = 1 << SW;

        logic          rst_n_s;
        logic          in_valid_s;
        logic          in_ready_s;
        logic [SW-1:0] sel_s;
        logic [1:0]    mode_s;
        logic          out_valid_s;
        logic          out_ready_s;
        logic [OW-1:0] y_s;
        logic [SW-1:0] y_idx_s;
        logic          out_last_s;
        logic          err_s;
        bit            done_b = 1'b0;
        int            seen_beats;
        beat_t         exp_q[$];

        onehot_decoder_pipe #(.SEL_W(SW), .OUT_W(OW)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_s),
            .in_valid  (in_valid_s),
            .in_ready  (in_ready_s),
            .sel       (sel_s),
            .mode      (mode_s),
            .out_valid (out_valid_s),
            .out_ready (out_ready_s),
            .y         (y_s),
            .y_idx     (y_idx_s),
            .out_last  (out_last_s),
            .err       (err_s)
        );

        // Reference: every accepted request expands into its full list of beats.
        task automatic push_req(input int s, input int m);
            beat_t b;
            if (m == 2) begin
                for (int i = s; i < OW; i++) begin
                    b.y    = 64'd1 << i;
                    b.idx  = 8'(i);
                    b.last = (i == OW - 1);
                    b.err  = 1'b0;
                    exp_q.push_back(b);
                end
            end else begin
                b.idx  = 8'(s);
                b.last = 1'b1;
                b.err  = (m == 3);
                b.y    = (m == 0) ? (64'd1 << s) :
                         (m == 1) ? ((64'd1 << (s + 1)) - 64'd1) : 64'd0;
                exp_q.push_back(b);
            end
        endtask

        task automatic step(input bit iv, input int s, input int m, input bit ordy);
            beat_t h;
            bit    exp_rdy;
            @(negedge clk);
            in_valid_s  = iv;
            sel_s       = SW'(s);
            mode_s      = 2'(m);
            out_ready_s = ordy;
            #1;
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
            check($sformatf("w%0d_in_ready", SW), in_ready_s, exp_rdy);
            check($sformatf("w%0d_out_valid", SW), out_valid_s, exp_q.size() != 0);
            if (out_valid_s && ordy) seen_beats++;
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                check($sformatf("w%0d_y", SW), y_s, h.y);
                check($sformatf("w%0d_idx", SW), y_idx_s, h.idx);
                check($sformatf("w%0d_last", SW), out_last_s, h.last);
                check($sformatf("w%0d_err", SW), err_s, h.err);
                if (ordy) void'(exp_q.pop_front());
            end else begin
                check($sformatf("w%0d_y_idle", SW), y_s, '0);
            end
            if (iv && exp_rdy) push_req(s, m);
        endtask

        initial begin
            rst_n_s     = 1'b0;
            in_valid_s  = 1'b0;
            sel_s       = '0;
            mode_s      = 2'b00;
            out_ready_s = 1'b1;
            seen_beats  = 0;
            wait (go_sel == g);
            @(negedge clk);
            rst_n_s = 1'b1;
            for (int m = 0; m < 2; m++)
                for (int s = 0; s < OW; s++)
                    step(1'b1, s, m, 1'b1);
            step(1'b0, 0, 0, 1'b1);
            step(1'b0, 0, 0, 1'b1);
            // Scan from zero must produce exactly OW beats.
            step(1'b1, 0, 2, 1'b1);
            seen_beats = 0;
            for (int i = 0; i < OW + 3; i++) step(1'b0, 0, 0, 1'b1);
            check($sformatf("w%0d_scan_beats", SW), 64'(seen_beats), 64'(OW));
            for (int i = 0; i < 400; i++)
                step($urandom_range(0, 3) != 0, int'($urandom_range(0, OW - 1)),
                     int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            for (int i = 0; i < OW + 4; i++) step(1'b0, 0, 0, 1'b1);
            done_b = 1'b1;
        end
    end

    function automatic bit sweep_done(input int g);
        case (g)
            0:       return sw[0].done_b;
            1:       return sw[1].done_b;
            default: return sw[2].done_b;
        endcase
    endfunction

    // ---------------- directed tests ----------------
    vec_t vecs[9];

    initial begin
        vecs[0] = '{3'd5, 2'b00, 8'h20, 3'd5, 1'b1, 1'b0};
        vecs[1] = '{3'd3, 2'b01, 8'h0F, 3'd3, 1'b1, 1'b0};
        vecs[2] = '{3'd2, 2'b11, 8'h00, 3'd2, 1'b1, 1'b1};
        vecs[3] = '{3'd0, 2'b00, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[4] = '{3'd7, 2'b01, 8'hFF, 3'd7, 1'b1, 1'b0};
        vecs[5] = '{3'd0, 2'b01, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[6] = '{3'd7, 2'b00, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[7] = '{3'd7, 2'b10, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[8] = '{3'd4, 2'b11, 8'h00, 3'd4, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sel       = '0;
        mode      = 2'b00;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y, 8'h00);
        check("rst_y_idx", y_idx, 3'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive_req(vecs[i].sel, vecs[i].mode, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            check_beat($sformatf("vec%0d", i), vecs[i].y, vecs[i].idx, vecs[i].last, vecs[i].err);
            @(negedge clk);
            check($sformatf("vec%0d_drained", i), out_valid, 1'b0);
        end

        // Thermometer beat held through a 3-cycle stall.
        drive_req(3'd3, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_beat("stall", 8'h0F, 3'd3, 1'b1, 1'b0);
            check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_in_ready", in_ready, 1'b1);
        @(negedge clk);
        check("stall_drained", out_valid, 1'b0);

        // Scan 5..7 with a one-hot request accepted on the last beat.
        drive_req(3'd5, 2'b10, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_beat("scan0", 8'h20, 3'd5, 1'b0, 1'b0);
        check("scan0_in_ready", in_ready, 1'b0);
        @(negedge clk);
        check_beat("scan1", 8'h40, 3'd6, 1'b0, 1'b0);
        @(negedge clk);
        check_beat("scan2", 8'h80, 3'd7, 1'b1, 1'b0);
        in_valid = 1'b1;
        sel      = 3'd0;
        mode     = 2'b00;
        #1;
        check("scan_last_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_beat("b2b", 8'h01, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("b2b_drained", out_valid, 1'b0);

        // Reset in the middle of a scan from zero.
        drive_req(3'd0, 2'b10, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_beat("mid0", 8'h01, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_beat("mid1", 8'h02, 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_y", y, 8'h00);
        check("mid_rst_idx", y_idx, 3'd0);
        check("mid_rst_last", out_last, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_valid", out_valid, 1'b0);
        end

        for (int g = 0; g < 3; g++) begin
            go_sel = g;
            for (int t = 0; t < 20000 && !sweep_done(g); t++) @(posedge clk);
            check($sformatf("sweep%0d_done", g), sweep_done(g), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
